// File: rtl/gb_lcd_capture.sv
// gb_lcd_capture: turns the Gameboy LCD pixel stream into linear 2bpp framebuffer writes,
// clearing the buffer while the LCD is off and reporting per-frame line counts.
module gb_lcd_capture #(
  parameter int WIDTH = 160,
  parameter int HEIGHT = 144,
  parameter int AW = 15,
  parameter logic [1:0] CLEAR_VAL = 2'b00
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          lcd_clkena,
  input  logic [1:0]    lcd_data,
  input  logic [1:0]    lcd_mode,
  input  logic          lcd_on,
  output logic [AW-1:0] fb_addr,
  output logic [1:0]    fb_data,
  output logic          fb_we,
  output logic          frame_done,
  output logic [7:0]    frame_lines,
  output logic [7:0]    frame_count,
  output logic          pix_overflow
);
  localparam int N = WIDTH * HEIGHT;
  localparam int XW = $clog2(WIDTH + 1);
  localparam int YW = $clog2(HEIGHT + 1);
  localparam logic [XW-1:0] XMAX = XW'(WIDTH);
  localparam logic [YW-1:0] YMAX = YW'(HEIGHT);
  typedef enum logic [1:0] {CLEAR, IDLE, SYNC, CAPTURE} state_t;
  state_t state_q, state_d;
  logic [AW-1:0] clear_addr_q, clear_addr_d, row_base_q, row_base_d, fb_addr_q, fb_addr_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [1:0] prev_mode_q, fb_data_q, fb_data_d;
  logic prev_on_q, fb_we_q, fb_we_d, frame_done_q, frame_done_d, pix_overflow_q, pix_overflow_d;
  logic [7:0] frame_lines_q, frame_lines_d, frame_count_q, frame_count_d;
  logic on_fall, on_rise, vbl, line_end, strobe;
  always_comb begin
    on_fall = prev_on_q & ~lcd_on;
    on_rise = ~prev_on_q & lcd_on;
    vbl = lcd_mode == 2'd1 && prev_mode_q != 2'd1;
    line_end = lcd_mode == 2'd0 && prev_mode_q == 2'd3;
    strobe = lcd_clkena && lcd_mode == 2'd3;
    state_d = state_q;
    clear_addr_d = clear_addr_q;
    row_base_d = row_base_q;
    x_d = x_q;
    y_d = y_q;
    fb_we_d = 1'b0;
    fb_addr_d = fb_addr_q;
    fb_data_d = fb_data_q;
    frame_done_d = 1'b0;
    frame_lines_d = frame_lines_q;
    frame_count_d = frame_count_q;
    pix_overflow_d = pix_overflow_q;
    if (state_q == CLEAR) begin
      fb_we_d = 1'b1;
      fb_addr_d = clear_addr_q;
      fb_data_d = CLEAR_VAL;
      clear_addr_d = clear_addr_q + AW'(1);
      pix_overflow_d = 1'b0;
      if (clear_addr_q == AW'(N - 1)) state_d = lcd_on ? SYNC : IDLE;
    end else if (on_fall) begin
      state_d = CLEAR;
      clear_addr_d = '0;
      pix_overflow_d = 1'b0;
    end else if ((state_q == IDLE && on_rise) || (state_q == SYNC && vbl)) begin
      state_d = CAPTURE;
      x_d = '0;
      y_d = '0;
      row_base_d = '0;
    end else if (state_q == CAPTURE) begin
      if (vbl) begin
        frame_done_d = 1'b1;
        frame_lines_d = 8'(y_q);
        frame_count_d = frame_count_q + 8'd1;
        x_d = '0;
        y_d = '0;
        row_base_d = '0;
      end else if (line_end) begin
        x_d = '0;
        y_d = y_q < YMAX ? y_q + YW'(1) : y_q;
        row_base_d = y_q < YMAX ? row_base_q + AW'(WIDTH) : row_base_q;
      end else if (strobe) begin
        if (x_q < XMAX && y_q < YMAX) begin
          fb_we_d = 1'b1;
          fb_addr_d = row_base_q + AW'(x_q);
          fb_data_d = lcd_data;
          x_d = x_q + XW'(1);
        end else pix_overflow_d = 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= CLEAR;
      clear_addr_q <= '0;
      row_base_q <= '0;
      x_q <= '0;
      y_q <= '0;
      prev_mode_q <= '0;
      prev_on_q <= 1'b0;
      fb_we_q <= 1'b0;
      fb_addr_q <= '0;
      fb_data_q <= '0;
      frame_done_q <= 1'b0;
      frame_lines_q <= '0;
      frame_count_q <= '0;
      pix_overflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      clear_addr_q <= clear_addr_d;
      row_base_q <= row_base_d;
      x_q <= x_d;
      y_q <= y_d;
      prev_mode_q <= lcd_mode;
      prev_on_q <= lcd_on;
      fb_we_q <= fb_we_d;
      fb_addr_q <= fb_addr_d;
      fb_data_q <= fb_data_d;
      frame_done_q <= frame_done_d;
      frame_lines_q <= frame_lines_d;
      frame_count_q <= frame_count_d;
      pix_overflow_q <= pix_overflow_d;
    end
  end
  assign fb_addr = fb_addr_q;
  assign fb_data = fb_data_q;
  assign fb_we = fb_we_q;
  assign frame_done = frame_done_q;
  assign frame_lines = frame_lines_q;
  assign frame_count = frame_count_q;
  assign pix_overflow = pix_overflow_q;
endmodule
